// File: rtl/uart_cmd_responder.sv
// Register-access command responder between the UART RX and TX FIFOs.
// Optional inter-byte timeout is built when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_responder #(
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_empty,
    output logic                  rx_rd,
    output logic [7:0]            tx_data,
    input  logic                  tx_full,
    output logic                  tx_wr,
    input  logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [7:0]            reg_rdata,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] RESP_ACK  = 8'h06;
    localparam logic [7:0] RESP_NAK  = 8'h15;
    localparam logic [7:0] RESP_CAN  = 8'h18;

    typedef enum logic [1:0] {IDLE, GET_ADDR, GET_DATA, RESP} state_t;

    state_t                state;
    logic                  is_write;
    logic                  addr_ok;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            resp;
    logic [7:0]            regs [DEPTH];
    logic                  in_range;
    logic                  timed_out;

    // Address bits above the register file width must all be zero.
    assign in_range  = (rx_data >> ADDR_WIDTH) == 8'd0;

    // Popping is suppressed during reset so queued bytes survive for the next packet.
    assign rx_rd     = ~rx_empty & ~reset & (state != RESP);
    assign tx_wr     = (state == RESP) & ~tx_full;
    assign tx_data   = resp;
    assign busy      = (state != IDLE);
    assign reg_rdata = regs[reg_addr];

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tcount;

    assign timed_out = rx_empty && (tcount == TLIMIT);

    // Counts idle cycles while waiting for the next byte of a packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcount <= '0;
        end else if ((state == GET_ADDR || state == GET_DATA) && !rx_rd && !timed_out) begin
            tcount <= tcount + 1'b1;
        end else begin
            tcount <= '0;
        end
    end
`else
    logic unused_timeout;

    assign timed_out      = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            is_write <= 1'b0;
            addr_ok  <= 1'b0;
            addr     <= '0;
            resp     <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_empty) begin
                        if (rx_data == CMD_READ || rx_data == CMD_WRITE) begin
                            is_write <= (rx_data == CMD_WRITE);
                            state    <= GET_ADDR;
                        end else begin
                            resp  <= RESP_NAK;
                            state <= RESP;
                        end
                    end
                end
                GET_ADDR: begin
                    if (!rx_empty) begin
                        addr    <= rx_data[ADDR_WIDTH-1:0];
                        addr_ok <= in_range;
                        if (is_write) begin
                            state <= GET_DATA;
                        end else begin
                            resp  <= in_range ? regs[rx_data[ADDR_WIDTH-1:0]] : RESP_NAK;
                            state <= RESP;
                        end
                    end else if (timed_out) begin
                        resp  <= RESP_CAN;
                        state <= RESP;
                    end
                end
                GET_DATA: begin
                    if (!rx_empty) begin
                        if (addr_ok) begin
                            regs[addr] <= rx_data;
                            resp       <= RESP_ACK;
                        end else begin
                            resp <= RESP_NAK;
                        end
                        state <= RESP;
                    end else if (timed_out) begin
                        resp  <= RESP_CAN;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (!tx_full) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed testbench for uart_cmd_responder with a behavioural RX FIFO and a TX capture log.
// The timeout scenario is compiled only when UART_CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_responder;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_rd;
    logic [7:0] tx_data;
    logic       tx_full;
    logic       tx_wr;
    logic [3:0] reg_addr;
    logic [7:0] reg_rdata;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_mem [256];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    int         cyc = 0;
    int         pop_cnt = 0;
    int         tx_cnt = 0;
    int         pop_cyc [256];
    int         tx_cyc [256];
    logic [7:0] tx_log [256];

    uart_cmd_responder #(
        .ADDR_WIDTH(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_empty(rx_empty),
        .rx_rd(rx_rd),
        .tx_data(tx_data),
        .tx_full(tx_full),
        .tx_wr(tx_wr),
        .reg_addr(reg_addr),
        .reg_rdata(reg_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rx_data  = rx_mem[rd_ptr & 255];
    assign rx_empty = (rd_ptr == wr_ptr);

    // RX FIFO pops and TX FIFO pushes, timestamped by cycle number.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_rd) begin
            rd_ptr <= rd_ptr + 1;
            pop_cyc[pop_cnt & 255] <= cyc;
            pop_cnt <= pop_cnt + 1;
        end
        if (tx_wr) begin
            tx_log[tx_cnt & 255] <= tx_data;
            tx_cyc[tx_cnt & 255] <= cyc;
            tx_cnt <= tx_cnt + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        rx_mem[wr_ptr & 255] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_tx(input int target, output bit to);
        int n = 0;
        while (tx_cnt < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        to = (tx_cnt < target);
    endtask

    task automatic wait_pop(input int target, output bit to);
        int n = 0;
        while (pop_cnt < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        to = (pop_cnt < target);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        tx_full  = 1'b0;
        reg_addr = 4'd0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rx_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_rd: got %b expected 0", rx_rd); end
        checks++; if (tx_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_wr: got %b expected 0", tx_wr); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++; if (reg_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_reg0: got %h expected 00", reg_rdata); end
        reg_addr = 4'd15;
        #1;
        checks++; if (reg_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_reg15: got %h expected 00", reg_rdata); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int bp = pop_cnt;
        int bt = tx_cnt;
        bit to;
        push(8'h57); push(8'h03); push(8'hA5);
        push(8'h52); push(8'h03);
        wait_tx(bt + 2, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL wr_rd_timeout: got %0d responses expected %0d", tx_cnt - bt, 2); end
        checks++; if (tx_log[bt] !== 8'h06) begin errors++; $display("[TB] FAIL write_ack: got %h expected 06", tx_log[bt]); end
        checks++; if (tx_log[bt+1] !== 8'hA5) begin errors++; $display("[TB] FAIL read_back: got %h expected a5", tx_log[bt+1]); end
        checks++; if (pop_cnt !== bp + 5) begin errors++; $display("[TB] FAIL wr_rd_pops: got %0d expected %0d", pop_cnt - bp, 5); end
        checks++; if (tx_cyc[bt] - pop_cyc[bp] !== 3) begin errors++; $display("[TB] FAIL write_latency: got %0d expected 3", tx_cyc[bt] - pop_cyc[bp]); end
        checks++; if (pop_cyc[bp+3] - tx_cyc[bt] !== 1) begin errors++; $display("[TB] FAIL next_cmd_gap: got %0d expected 1", pop_cyc[bp+3] - tx_cyc[bt]); end
        checks++; if (tx_cyc[bt+1] - pop_cyc[bp+3] !== 2) begin errors++; $display("[TB] FAIL read_latency: got %0d expected 2", tx_cyc[bt+1] - pop_cyc[bp+3]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wr_rd_idle: got %b expected 0", busy); end
        reg_addr = 4'd3;
        #1;
        checks++; if (reg_rdata !== 8'hA5) begin errors++; $display("[TB] FAIL local_read3: got %h expected a5", reg_rdata); end
    endtask

    task automatic test_out_of_range();
        int bp = pop_cnt;
        int bt = tx_cnt;
        bit to;
        logic [7:0] exp;
        push(8'h57); push(8'h10); push(8'h11);
        wait_tx(bt + 1, to);
        checks++; if (to || tx_log[bt] !== 8'h15) begin errors++; $display("[TB] FAIL oor_write_nak: got %h expected 15", tx_log[bt]); end
        checks++; if (pop_cnt !== bp + 3) begin errors++; $display("[TB] FAIL oor_write_pops: got %0d expected 3", pop_cnt - bp); end
        for (int a = 0; a < 16; a++) begin
            reg_addr = a[3:0];
            exp = (a == 3) ? 8'hA5 : 8'h00;
            #1;
            checks++; if (reg_rdata !== exp) begin errors++; $display("[TB] FAIL oor_reg%0d: got %h expected %h", a, reg_rdata, exp); end
        end
        push(8'h52); push(8'h10);
        wait_tx(bt + 2, to);
        checks++; if (to || tx_log[bt+1] !== 8'h15) begin errors++; $display("[TB] FAIL oor_read_nak: got %h expected 15", tx_log[bt+1]); end
        checks++; if (pop_cnt !== bp + 5) begin errors++; $display("[TB] FAIL oor_read_pops: got %0d expected 5", pop_cnt - bp); end
    endtask

    task automatic test_bad_command();
        int bp = pop_cnt;
        int bt = tx_cnt;
        bit to;
        push(8'h41);
        wait_tx(bt + 1, to);
        checks++; if (to || tx_log[bt] !== 8'h15) begin errors++; $display("[TB] FAIL bad_cmd_nak: got %h expected 15", tx_log[bt]); end
        checks++; if (pop_cnt !== bp + 1) begin errors++; $display("[TB] FAIL bad_cmd_pops: got %0d expected 1", pop_cnt - bp); end
        checks++; if (tx_cyc[bt] - pop_cyc[bp] !== 1) begin errors++; $display("[TB] FAIL bad_cmd_latency: got %0d expected 1", tx_cyc[bt] - pop_cyc[bp]); end
        pulse_reset();
        push(8'h52); push(8'h00);
        push(8'h52); push(8'h03);
        wait_tx(bt + 3, to);
        checks++; if (to || tx_log[bt+1] !== 8'h00) begin errors++; $display("[TB] FAIL read0_after_reset: got %h expected 00", tx_log[bt+1]); end
        checks++; if (tx_log[bt+2] !== 8'h00) begin errors++; $display("[TB] FAIL read3_after_reset: got %h expected 00", tx_log[bt+2]); end
    endtask

    task automatic test_back_to_back();
        int bp;
        int bt = tx_cnt;
        bit to;
        push(8'h57); push(8'h07); push(8'h3C);
        wait_tx(bt + 1, to);
        checks++; if (to || tx_log[bt] !== 8'h06) begin errors++; $display("[TB] FAIL bp_write_ack: got %h expected 06", tx_log[bt]); end
        bp = pop_cnt;
        tx_full = 1'b1;
        push(8'h52); push(8'h07);
        push(8'h52); push(8'h03);
        repeat (10) @(negedge clk);
        checks++; if (tx_cnt !== bt + 1) begin errors++; $display("[TB] FAIL bp_no_push: got %0d pushes expected 0", tx_cnt - bt - 1); end
        checks++; if (tx_wr !== 1'b0) begin errors++; $display("[TB] FAIL bp_tx_wr: got %b expected 0", tx_wr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL bp_busy: got %b expected 1", busy); end
        checks++; if (pop_cnt !== bp + 2) begin errors++; $display("[TB] FAIL bp_pops_held: got %0d expected 2", pop_cnt - bp); end
        checks++; if (tx_data !== 8'h3C) begin errors++; $display("[TB] FAIL bp_tx_data: got %h expected 3c", tx_data); end
        tx_full = 1'b0;
        wait_tx(bt + 3, to);
        checks++; if (to || tx_log[bt+1] !== 8'h3C) begin errors++; $display("[TB] FAIL bp_release_data: got %h expected 3c", tx_log[bt+1]); end
        checks++; if (tx_log[bt+2] !== 8'h00) begin errors++; $display("[TB] FAIL bp_next_packet: got %h expected 00", tx_log[bt+2]); end
        checks++; if (pop_cnt !== bp + 4) begin errors++; $display("[TB] FAIL bp_total_pops: got %0d expected 4", pop_cnt - bp); end
    endtask

    task automatic test_mid_packet_reset();
        int bp = pop_cnt;
        int bt = tx_cnt;
        bit to;
        push(8'h57); push(8'h05);
        wait_pop(bp + 2, to);
        checks++; if (to || busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy); end
        pulse_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_idle_after_reset: got %b expected 0", busy); end
        push(8'h52); push(8'h05);
        wait_tx(bt + 1, to);
        checks++; if (to || tx_log[bt] !== 8'h00) begin errors++; $display("[TB] FAIL mid_read5: got %h expected 00", tx_log[bt]); end
        reg_addr = 4'd5;
        #1;
        checks++; if (reg_rdata !== 8'h00) begin errors++; $display("[TB] FAIL mid_reg5: got %h expected 00", reg_rdata); end
    endtask

`ifdef UART_CMD_TIMEOUT_EN
    task automatic test_timeout();
        int bp = pop_cnt;
        int bt = tx_cnt;
        int lat;
        bit to;
        push(8'h57);
        wait_tx(bt + 1, to);
        lat = tx_cyc[bt] - pop_cyc[bp];
        checks++; if (to || tx_log[bt] !== 8'h18) begin errors++; $display("[TB] FAIL timeout_resp: got %h expected 18", tx_log[bt]); end
        checks++; if (lat < 15 || lat > 18) begin errors++; $display("[TB] FAIL timeout_latency: got %0d expected 15..18", lat); end
        push(8'h41);
        wait_tx(bt + 2, to);
        checks++; if (to || tx_log[bt+1] !== 8'h15) begin errors++; $display("[TB] FAIL late_byte_as_cmd: got %h expected 15", tx_log[bt+1]); end
        checks++; if (pop_cnt !== bp + 2) begin errors++; $display("[TB] FAIL timeout_pops: got %0d expected 2", pop_cnt - bp); end
    endtask
`endif

    initial begin
        reset    = 1'b1;
        tx_full  = 1'b0;
        reg_addr = 4'd0;
        test_reset();
        test_write_read();
        test_out_of_range();
        test_bad_command();
        test_back_to_back();
        test_mid_packet_reset();
`ifdef UART_CMD_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
